// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache memory path: source encoding,
// request/return payload structs and the transaction ID width used by both caches.
package wt_cache_pkg;

  localparam int unsigned WtTidWidth   = 2;
  localparam int unsigned WtReqWidth   = 128;
  localparam int unsigned WtRtrnWidth  = 128;

  typedef enum logic {
    MEM_SRC_ICACHE = 1'b0,
    MEM_SRC_DCACHE = 1'b1
  } mem_src_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [WtTidWidth:0]   tid;
    logic [WtReqWidth-1:0] data;
  } wt_mem_req_t;

  typedef struct packed {
    logic [WtTidWidth:0]    tid;
    logic                   last;
    logic [WtRtrnWidth-1:0] data;
  } wt_mem_rtrn_t;

endpackage

// File: rtl/wt_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves to the losing side after
// every accepted grant so a lone requester hands priority to the other side.
module wt_rr_arb2
  import wt_cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  mem_src_e rr_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (rr_q == MEM_SRC_ICACHE) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= MEM_SRC_ICACHE;
    end else if (advance && (gnt != 2'b00)) begin
      rr_q <= gnt[0] ? MEM_SRC_DCACHE : MEM_SRC_ICACHE;
    end
  end

endmodule

// File: rtl/wt_mem_arbiter.sv
// Shares the downstream memory request channel between icache and dcache,
// tags requests with their source, counts in-flight transactions and routes returns.
//
// state | meaning
// IDLE  | output register empty
// SEND  | output register holds a request, mem_req_o high
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned ReqWidth       = WtReqWidth,
  parameter int unsigned RtrnWidth      = WtRtrnWidth,
  parameter int unsigned TidWidth       = WtTidWidth,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 block_i,
  input  logic                 ic_req_i,
  input  logic [ReqWidth-1:0]  ic_data_i,
  input  logic [TidWidth-1:0]  ic_tid_i,
  output logic                 ic_ack_o,
  input  logic                 dc_req_i,
  input  logic [ReqWidth-1:0]  dc_data_i,
  input  logic [TidWidth-1:0]  dc_tid_i,
  output logic                 dc_ack_o,
  output logic                 mem_req_o,
  output logic [ReqWidth-1:0]  mem_data_o,
  output logic [TidWidth:0]    mem_tid_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_rtrn_vld_i,
  input  logic [TidWidth:0]    mem_rtrn_tid_i,
  input  logic                 mem_rtrn_last_i,
  input  logic [RtrnWidth-1:0] mem_rtrn_data_i,
  output logic                 ic_rtrn_vld_o,
  output logic [TidWidth-1:0]  ic_rtrn_tid_o,
  output logic [RtrnWidth-1:0] ic_rtrn_data_o,
  output logic                 dc_rtrn_vld_o,
  output logic [TidWidth-1:0]  dc_rtrn_tid_o,
  output logic [RtrnWidth-1:0] dc_rtrn_data_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  arb_state_e          state_q, state_d;
  logic [CntWidth-1:0] cnt_q [2];
  logic [1:0]          req, elig, gnt, inc, dec;
  logic                capture;
  mem_src_e            rtrn_src;
  logic [ReqWidth-1:0] mem_data_q;
  logic [TidWidth:0]   mem_tid_q;
  logic                ic_rtrn_vld_q, dc_rtrn_vld_q;
  logic [TidWidth-1:0] rtrn_tid_q;
  logic [RtrnWidth-1:0] rtrn_data_q;
  logic                err_q;

  assign req = {dc_req_i, ic_req_i};

  always_comb begin
    elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req[i] && (cnt_q[i] < CntWidth'(MaxOutstanding)) && !block_i;
    end
  end

  // A held request blocks new captures until downstream accepts it.
  assign capture = ((state_q == ARB_IDLE) || mem_ack_i) && (gnt != 2'b00) && !rst_i;

  wt_rr_arb2 u_rr_arb2 (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (elig),
    .advance (capture),
    .gnt     (gnt)
  );

  assign ic_ack_o = capture && gnt[0];
  assign dc_ack_o = capture && gnt[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (capture) state_d = ARB_SEND;
      ARB_SEND: if (mem_ack_i && !capture) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      mem_data_q <= '0;
      mem_tid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        mem_data_q <= gnt[1] ? dc_data_i : ic_data_i;
        mem_tid_q  <= gnt[1] ? {1'b1, dc_tid_i} : {1'b0, ic_tid_i};
      end
    end
  end

  assign rtrn_src = mem_src_e'(mem_rtrn_tid_i[TidWidth]);
  assign inc      = gnt & {2{capture}};
  assign dec[0]   = mem_rtrn_vld_i && mem_rtrn_last_i && (rtrn_src == MEM_SRC_ICACHE);
  assign dec[1]   = mem_rtrn_vld_i && mem_rtrn_last_i && (rtrn_src == MEM_SRC_DCACHE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          if (cnt_q[i] == '0) err_q <= 1'b1;
          else                cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ic_rtrn_vld_q <= 1'b0;
      dc_rtrn_vld_q <= 1'b0;
      rtrn_tid_q    <= '0;
      rtrn_data_q   <= '0;
    end else begin
      ic_rtrn_vld_q <= mem_rtrn_vld_i && (rtrn_src == MEM_SRC_ICACHE);
      dc_rtrn_vld_q <= mem_rtrn_vld_i && (rtrn_src == MEM_SRC_DCACHE);
      if (mem_rtrn_vld_i) begin
        rtrn_tid_q  <= mem_rtrn_tid_i[TidWidth-1:0];
        rtrn_data_q <= mem_rtrn_data_i;
      end
    end
  end

  assign mem_req_o      = (state_q == ARB_SEND);
  assign mem_data_o     = mem_data_q;
  assign mem_tid_o      = mem_tid_q;
  assign ic_rtrn_vld_o  = ic_rtrn_vld_q;
  assign dc_rtrn_vld_o  = dc_rtrn_vld_q;
  assign ic_rtrn_tid_o  = rtrn_tid_q;
  assign dc_rtrn_tid_o  = rtrn_tid_q;
  assign ic_rtrn_data_o = rtrn_data_q;
  assign dc_rtrn_data_o = rtrn_data_q;
  assign busy_o         = (state_q == ARB_SEND) || (cnt_q[0] != '0) || (cnt_q[1] != '0);
  assign err_o          = err_q;

endmodule
